mlu_serial: RTL and testbench

MLU_SERIAL -- requirements
Module: mlu_serial

---
 rtl/common.sv | 19 +
 rtl/mlu_serial_slice.sv | 46 ++++
 rtl/mlu_serial.sv | 216 +++++++++++++++++++++
 tb/tb_mlu_serial.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared MLU operation codes and the mlu_serial controller state type.
package common;

  localparam logic [2:0] MLU_ADD  = 3'd0;
  localparam logic [2:0] MLU_SUB  = 3'd1;
  localparam logic [2:0] MLU_AND  = 3'd2;
  localparam logic [2:0] MLU_OR   = 3'd3;
  localparam logic [2:0] MLU_XOR  = 3'd4;
  localparam logic [2:0] MLU_NOT  = 3'd5;
  localparam logic [2:0] MLU_NOP0 = 3'd6;
  localparam logic [2:0] MLU_NOP1 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mlu_serial_state_t;

endpackage

// File: rtl/mlu_serial_slice.sv
// One SLICE_W-bit slice of the serial MLU (purely combinational).
// MLU_SERIAL_OVERFLOW_EN adds the signed-overflow output VOUT.
module mlu_serial_slice
  import common::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic [2:0]         OP,
  input  logic               CIN,
  output logic [SLICE_W-1:0] OUT,
  output logic               COUT
`ifdef MLU_SERIAL_OVERFLOW_EN
  ,
  output logic               VOUT
`endif
);

  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W:0]   sum;
  logic               arith;

  always_comb begin
    arith = (OP == MLU_ADD) || (OP == MLU_SUB);
    b_eff = (OP == MLU_SUB) ? ~B : B;
    sum   = {1'b0, A} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, CIN};
    COUT  = arith & sum[SLICE_W];
    case (OP)
      MLU_ADD, MLU_SUB: OUT = sum[SLICE_W-1:0];
      MLU_AND:          OUT = A & B;
      MLU_OR:           OUT = A | B;
      MLU_XOR:          OUT = A ^ B;
      MLU_NOT:          OUT = ~A;
      default:          OUT = '0;
    endcase
  end

`ifdef MLU_SERIAL_OVERFLOW_EN
  // Overflow when both addends share a sign that the sum does not.
  always_comb begin
    VOUT = arith & (A[SLICE_W-1] == b_eff[SLICE_W-1]) & (sum[SLICE_W-1] != A[SLICE_W-1]);
  end
`endif

endmodule

// File: rtl/mlu_serial.sv
// Bit-serial (slice-per-cycle) MLU with valid/ready handshakes on both sides.
// MLU_SERIAL_OVERFLOW_EN adds the V (signed overflow) output.
module mlu_serial
  import common::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 4
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             C_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             Z,
  output logic             C,
  output logic             N,
`ifdef MLU_SERIAL_OVERFLOW_EN
  output logic             V,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  mlu_serial_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, zacc_q, zacc_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d;
  logic             accept, last;

  logic [SLICE_W-1:0] sl_out;
  logic               sl_cout;
`ifdef MLU_SERIAL_OVERFLOW_EN
  logic               sl_vout;
  logic               v_q, v_d;
`endif

  // Operands are shifted right each cycle so the active slice is always bits [SLICE_W-1:0].
  mlu_serial_slice #(.SLICE_W(SLICE_W)) u_slice (
    .A    (a_q[SLICE_W-1:0]),
    .B    (b_q[SLICE_W-1:0]),
    .OP   (op_q),
    .CIN  (carry_q),
    .OUT  (sl_out),
    .COUT (sl_cout)
`ifdef MLU_SERIAL_OVERFLOW_EN
    ,
    .VOUT (sl_vout)
`endif
  );

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = DONE;
      DONE:    if (OUT_READY) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
    OUT_VALID = (state_q == DONE);
    accept    = IN_VALID && IN_READY;
    last      = (state_q == RUN) && (cnt_q == CNT_LAST);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    zacc_d  = zacc_q;
    res_d   = res_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
`ifdef MLU_SERIAL_OVERFLOW_EN
    v_d     = v_q;
`endif
    if (accept) begin
      a_d     = A;
      b_d     = B;
      op_d    = OP;
      carry_d = C_IN;
      cnt_d   = '0;
      zacc_d  = 1'b1;
      res_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> SLICE_W;
      b_d     = b_q >> SLICE_W;
      carry_d = sl_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      zacc_d  = zacc_q & (sl_out == '0);
      // Result fills from the top so it lands LSB-aligned after NSLICE shifts.
      res_d   = (res_q >> SLICE_W) | (WIDTH'(sl_out) << (WIDTH - SLICE_W));
      if (last) begin
        out_d = res_d;
        z_d   = zacc_d;
        c_d   = sl_cout;
        n_d   = res_d[WIDTH-1];
`ifdef MLU_SERIAL_OVERFLOW_EN
        v_d   = sl_vout;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      zacc_q  <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef MLU_SERIAL_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      zacc_q  <= zacc_d;
      res_q   <= res_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
`ifdef MLU_SERIAL_OVERFLOW_EN
      v_q     <= v_d;
`endif
    end
  end

  assign OUT = out_q;
  assign Z   = z_q;
  assign C   = c_q;
  assign N   = n_q;
`ifdef MLU_SERIAL_OVERFLOW_EN
  assign V   = v_q;
`endif

`ifdef FORMAL
  logic [WIDTH-1:0] fa_q, fb_q, f_out;
  logic [2:0]       fop_q;
  logic             fcin_q, f_c;
  logic [WIDTH:0]   f_sum;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      fa_q   <= '0;
      fb_q   <= '0;
      fop_q  <= '0;
      fcin_q <= 1'b0;
    end else if (accept) begin
      fa_q   <= A;
      fb_q   <= B;
      fop_q  <= OP;
      fcin_q <= C_IN;
    end
  end

  always_comb begin
    f_sum = '0;
    f_out = '0;
    f_c   = 1'b0;
    case (fop_q)
      MLU_ADD: begin
        f_sum = {1'b0, fa_q} + {1'b0, fb_q} + (WIDTH+1)'(fcin_q);
        f_out = f_sum[WIDTH-1:0];
        f_c   = f_sum[WIDTH];
      end
      MLU_SUB: begin
        f_sum = {1'b0, fa_q} + {1'b0, ~fb_q} + (WIDTH+1)'(fcin_q);
        f_out = f_sum[WIDTH-1:0];
        f_c   = f_sum[WIDTH];
      end
      MLU_AND: f_out = fa_q & fb_q;
      MLU_OR:  f_out = fa_q | fb_q;
      MLU_XOR: f_out = fa_q ^ fb_q;
      MLU_NOT: f_out = ~fa_q;
      default: f_out = '0;
    endcase
  end

  ap_result: assert property (@(posedge CLK) disable iff (!N_RST)
    OUT_VALID |-> (OUT == f_out) && (C == f_c) && (Z == (f_out == '0)) && (N == f_out[WIDTH-1]));
`endif

endmodule

// File: tb/tb_mlu_serial.sv
// Self-checking bench for mlu_serial: word-level scoreboard model plus directed literal vectors.
module tb_mlu_serial;
  import common::*;

  localparam int NS = 8;

  logic        CLK = 1'b0;
  logic        N_RST = 1'b1;
  logic [31:0] A = '0, B = '0, OUT;
  logic [2:0]  OP = '0;
  logic        C_IN = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b1;
  logic        IN_READY, Z, C, N, OUT_VALID;
  logic [7:0]  A8 = '0, B8 = '0, OUT8;
  logic [2:0]  OP8 = '0;
  logic        CI8 = 1'b0, IV8 = 1'b0, OR8 = 1'b1;
  logic        IR8, Z8, C8, N8, OV8;
`ifdef MLU_SERIAL_OVERFLOW_EN
  logic        V, V8;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  mlu_serial #(.WIDTH(32), .SLICE_W(4)) dut (
    .CLK(CLK), .N_RST(N_RST), .A(A), .B(B), .OP(OP), .C_IN(C_IN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT(OUT), .Z(Z), .C(C), .N(N),
`ifdef MLU_SERIAL_OVERFLOW_EN
    .V(V),
`endif
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  mlu_serial #(.WIDTH(8), .SLICE_W(8)) dut8 (
    .CLK(CLK), .N_RST(N_RST), .A(A8), .B(B8), .OP(OP8), .C_IN(CI8),
    .IN_VALID(IV8), .IN_READY(IR8), .OUT(OUT8), .Z(Z8), .C(C8), .N(N8),
`ifdef MLU_SERIAL_OVERFLOW_EN
    .V(V8),
`endif
    .OUT_VALID(OV8), .OUT_READY(OR8)
  );

  typedef struct packed { logic [31:0] out; logic c; logic v; } mres_t;

  function automatic mres_t mdl(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic ci);
    mres_t r;
    logic [32:0] s;
    logic [31:0] bb;
    r = '0;
    bb = (op == MLU_SUB) ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + 33'(ci);
    case (op)
      MLU_ADD, MLU_SUB: begin
        r.out = s[31:0];
        r.c   = s[32];
        r.v   = (a[31] == bb[31]) && (s[31] != a[31]);
      end
      MLU_AND: r.out = a & b;
      MLU_OR:  r.out = a | b;
      MLU_XOR: r.out = a ^ b;
      MLU_NOT: r.out = ~a;
      default: r.out = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: an accepted op delivers its result NS edges later and is held until taken.
  int          m_left = 0;
  logic        m_have = 1'b0;
  mres_t       m_pend = '0;
  logic [31:0] m_out = '0;
  logic        m_z = 1'b0, m_c = 1'b0, m_n = 1'b0, m_v = 1'b0;
  logic        m_ready;

  assign m_ready = (m_left == 0 && !m_have) || (m_have && OUT_READY);

  always @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      m_left <= 0;
      m_have <= 1'b0;
      m_out  <= '0;
      m_z    <= 1'b0;
      m_c    <= 1'b0;
      m_n    <= 1'b0;
      m_v    <= 1'b0;
    end else begin
      if (m_have && OUT_READY) m_have <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_have <= 1'b1;
          m_out  <= m_pend.out;
          m_z    <= (m_pend.out == '0);
          m_c    <= m_pend.c;
          m_n    <= m_pend.out[31];
          m_v    <= m_pend.v;
        end
      end
      if (IN_VALID && m_ready) begin
        m_pend <= mdl(A, B, OP, C_IN);
        m_left <= NS;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic ci);
    A = a; B = b; OP = op; C_IN = ci; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] a, b; logic [2:0] op; logic ci; logic [31:0] eo; logic ec;
  } vec_t;
  vec_t tv [7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    fork
      begin : directed
        tv[0] = '{32'h12340000, 32'h00005678, MLU_OR,   1'b0, 32'h12345678, 1'b0};
        tv[1] = '{32'h0F0F0000, 32'hFFFFFFFF, MLU_NOT,  1'b0, 32'hF0F0FFFF, 1'b0};
        tv[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, MLU_NOP0, 1'b1, 32'h00000000, 1'b0};
        tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, MLU_NOP1, 1'b1, 32'h00000000, 1'b0};
        tv[4] = '{32'h7FFFFFFF, 32'h00000000, MLU_ADD,  1'b1, 32'h80000000, 1'b0};
        tv[5] = '{32'h0000000A, 32'h00000003, MLU_SUB,  1'b1, 32'h00000007, 1'b1};
        tv[6] = '{32'h00000003, 32'h00000003, MLU_SUB,  1'b0, 32'hFFFFFFFF, 1'b0};

        #2 N_RST = 1'b0;
        repeat (2) tick();
        chk("rst_out", OUT, 32'h0);
        chk("rst_flags", 32'({Z, C, N, OUT_VALID}), 32'h0);
        chk("rst_ready", 32'(IN_READY), 32'h1);
        N_RST = 1'b1;
        OUT_READY = 1'b0;
        tick();
        chk("rel_ready", 32'(IN_READY), 32'h1);

        issue(32'hFFFFFFFF, 32'h1, MLU_ADD, 1'b0);
        repeat (7) tick();
        chk("add_early", 32'(OUT_VALID), 32'h0);
        tick();
        chk("add_valid", 32'(OUT_VALID), 32'h1);
        chk("add_out", OUT, 32'h0);
        chk("add_zcn", 32'({Z, C, N}), 32'b110);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        issue(32'h5, 32'h7, MLU_SUB, 1'b1);
        repeat (8) tick();
        chk("sub_out", OUT, 32'hFFFFFFFE);
        chk("sub_zcn", 32'({Z, C, N}), 32'b001);
`ifdef MLU_SERIAL_OVERFLOW_EN
        chk("sub_v", 32'(V), 32'h0);
`endif
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        issue(32'hA5A5A5A5, 32'hFFFF0000, MLU_XOR, 1'b0);
        repeat (8) tick();
        chk("xor_out", OUT, 32'h5A5AA5A5);
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("xor_hold", OUT, 32'h5A5AA5A5);
          chk("xor_hold_vld", 32'(OUT_VALID), 32'h1);
        end
        OUT_READY = 1'b1;
        #1;
        chk("xor_ready", 32'(IN_READY), 32'h1);
        tick();
        chk("xor_idle_vld", 32'(OUT_VALID), 32'h0);
        chk("xor_retain", OUT, 32'h5A5AA5A5);
        OUT_READY = 1'b0;

        issue(32'h1, 32'h2, MLU_ADD, 1'b0);
        repeat (8) tick();
        chk("b2b_first", OUT, 32'h3);
        A = 32'hF0F0F0F0; B = 32'h0FF00FF0; OP = MLU_AND; C_IN = 1'b0;
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        tick();
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        chk("b2b_run", 32'(OUT_VALID), 32'h0);
        chk("b2b_retain", OUT, 32'h3);
        repeat (7) tick();
        chk("b2b_early", 32'(OUT_VALID), 32'h0);
        tick();
        chk("b2b_valid", 32'(OUT_VALID), 32'h1);
        chk("b2b_out", OUT, 32'h00F000F0);
        OUT_READY = 1'b1;
        tick();

        issue(32'h12345678, 32'h1, MLU_ADD, 1'b0);
        repeat (3) tick();
        #2 N_RST = 1'b0;
        #1;
        chk("midrst_out", OUT, 32'h0);
        chk("midrst_flags", 32'({Z, C, N, OUT_VALID}), 32'h0);
        repeat (2) tick();
        N_RST = 1'b1;
        tick();
        chk("midrst_ready", 32'(IN_READY), 32'h1);
        repeat (10) tick();
        chk("midrst_novld", 32'(OUT_VALID), 32'h0);

        for (int i = 0; i < 7; i++) begin
          issue(tv[i].a, tv[i].b, tv[i].op, tv[i].ci);
          repeat (NS) tick();
          chk("tbl_out", OUT, tv[i].eo);
          chk("tbl_c", 32'(C), 32'(tv[i].ec));
        end
        tick();

        A8 = 8'h7F; B8 = 8'h01; OP8 = MLU_ADD; CI8 = 1'b0; IV8 = 1'b1;
        tick();
        IV8 = 1'b0;
        chk("w8_run", 32'(OV8), 32'h0);
        tick();
        chk("w8_valid", 32'(OV8), 32'h1);
        chk("w8_out", 32'(OUT8), 32'h80);
        chk("w8_zcn", 32'({Z8, C8, N8}), 32'b001);
`ifdef MLU_SERIAL_OVERFLOW_EN
        chk("w8_v", 32'(V8), 32'h1);
`endif
        A8 = 8'h80; B8 = 8'h01; OP8 = MLU_SUB; CI8 = 1'b1; IV8 = 1'b1;
        tick();
        IV8 = 1'b0;
        tick();
        chk("w8sub_out", 32'(OUT8), 32'h7F);
        chk("w8sub_zcn", 32'({Z8, C8, N8}), 32'b010);
`ifdef MLU_SERIAL_OVERFLOW_EN
        chk("w8sub_v", 32'(V8), 32'h1);
`endif
        repeat (2) tick();
      end
      begin : monitor
        forever begin
          @(negedge CLK);
          chk("mdl_ready", 32'(IN_READY), 32'(m_ready));
          chk("mdl_valid", 32'(OUT_VALID), 32'(m_have));
          chk("mdl_out", OUT, m_out);
          chk("mdl_zcn", 32'({Z, C, N}), 32'({m_z, m_c, m_n}));
`ifdef MLU_SERIAL_OVERFLOW_EN
          chk("mdl_v", 32'(V), 32'(m_v));
`endif
        end
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
